match_arbiter: RTL
==================

Name: match_arbiter

Overview:
- Round-robin scheduler that shares one cypher/nibble match engine between NREQ requesters.
- The engine has a 16-bit cypher, a 4-bit compared nibble, a read strobe, and match/sum results.
- Per transaction: grants one requester, drives the engine operands, issues a single read strobe, waits for completion or timeout, then returns match/sum to the granted requester with a one-cycle ack.
- Sits between the requester clients and the engine's read/result interface.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 64, max WAIT cycles before the transaction is aborted (>=2)
IDW, 2, grant index width, ceil(log2(NREQ))

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request level; held until ack
req_cypher  in  NREQ*16  flattened operands; requester i at bits [16i+15:16i]
req_compared  in  NREQ*4  flattened nibbles; requester i at bits [4i+3:4i]
ack  out  NREQ  one-hot, one-cycle result strobe to the granted requester
res_match  out  1  returned match result
res_sum  out  8  returned sum result
res_timeout  out  1  transaction aborted by timeout
busy  out  1  high in every state except IDLE
grant_id  out  IDW  index of the current/last granted requester
eng_read  out  1  one-cycle start strobe to the engine
eng_cypher  out  16  registered cypher operand
eng_compared  out  4  registered compared operand
eng_done  in  1  engine completion strobe; results valid in the same cycle
eng_match  in  1  engine match result
eng_sum  in  8  engine sum result

Behaviour:
- Clock and reset: single clock, clock. Reset is synchronous and active-high; all state updates on the rising edge.
- Reset values:
  - State = IDLE.
  - ack, eng_read, busy, res_match, res_timeout = 0; res_sum = 0.
  - eng_cypher = 0; eng_compared = 0; grant_id = 0.
  - Internal last_grant = NREQ-1, so requester 0 has first priority.
- Reset mid-transaction: aborts immediately. No ack is issued and the engine is not strobed again.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is high, pick the first set bit scanning upward from last_grant+1, with wrap-around modulo NREQ.
  - Latch that requester's operands into eng_cypher/eng_compared, set grant_id, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - eng_read = 1 for exactly this cycle; clear the timer; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - If eng_done = 1: capture eng_match and eng_sum, set res_timeout = 0, go to RESP.
  - Else if timer == TIMEOUT-1: set res_match = 0, res_sum = 0, res_timeout = 1, go to RESP.
  - If eng_done and timeout occur in the same cycle, eng_done wins.
- RESP:
  - ack[grant_id] = 1 for this cycle only; res_* are valid this cycle.
  - last_grant = grant_id; go to IDLE.
- Result hold: res_match, res_sum and res_timeout hold their values until the next RESP.
- Operand stability: eng_cypher/eng_compared stay constant from ISSUE through RESP.
- Latency:
  - req sampled in IDLE at cycle t → eng_read at t+1.
  - If eng_done arrives at t+1+k (k>=1), ack occurs at t+2+k.
  - Minimum request-to-ack latency is 3 cycles.
- eng_done is ignored in IDLE, ISSUE and RESP. A stray done never creates an ack.
- A requester dropping req after grant: the transaction still completes and is still acked. req is not re-sampled until IDLE.
- A requester reasserting req right after its ack: it loses to any other pending requester, because round-robin starts after last_grant.
- Exactly one transaction is outstanding at a time; eng_read never fires while busy is in WAIT.
- ack is never multi-hot and is never asserted outside RESP.

Test Plan:
1. Reset, then req=4'b0001 with cypher 16'hABCD, nibble 4'hB; engine returns done 3 cycles after read with match=1, sum=8'd5 → eng_read one pulse with eng_cypher=16'hABCD; ack=4'b0001 at 5 cycles after req; res_match=1, res_sum=5, res_timeout=0.
2. req=4'b1111 held continuously, engine done 1 cycle after read → grant order 0,1,2,3,0; each ack one-hot; 4 cycles per transaction.
3. Engine never asserts done, TIMEOUT=8 → ack 8 cycles into WAIT with res_timeout=1, res_sum=0, res_match=0; next requester is served normally.
4. Assert reset during WAIT for requester 2 → no ack; busy=0 and eng_read=0 next cycle; after reset, req=4'b0100 is granted index 2 fresh.
5. eng_done pulsed while IDLE, plus done coinciding with the timeout cycle → no ack for the IDLE pulse; coincident case returns the engine result with res_timeout=0.
6. Requester 1 drops req during WAIT while requester 3 is pending → ack[1] still pulses; requester 3 is granted next.

Source files
------------

// File: rtl/match_arbiter.sv
// Round-robin front end that shares one cypher/nibble match engine among
// NREQ requesters. Each transaction grants one requester, issues a single
// engine read, waits for the engine or a timeout, then acks the result.
module match_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int IDW     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*16-1:0]   req_cypher,
  input  logic [NREQ*4-1:0]    req_compared,
  output logic [NREQ-1:0]      ack,
  output logic                 res_match,
  output logic [7:0]           res_sum,
  output logic                 res_timeout,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 eng_read,
  output logic [15:0]          eng_cypher,
  output logic [3:0]           eng_compared,
  input  logic                 eng_done,
  input  logic                 eng_match,
  input  logic [7:0]           eng_sum
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [IDW-1:0]  last_grant;
  logic [TW-1:0]   timer;
  logic            pick_vld;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  idx;
  logic            wait_expired;

  assign wait_expired = (timer == TW'(TIMEOUT - 1));

  // Round-robin pick: scan downward so the smallest offset after last_grant wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = IDW'((int'(last_grant) + off) % NREQ);
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state selection; engine done takes priority over the timeout.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (eng_done || wait_expired) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, timer, result capture and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      eng_cypher   <= '0;
      eng_compared <= '0;
      grant_id     <= '0;
      last_grant   <= IDW'(NREQ - 1);
      timer        <= '0;
      res_match    <= 1'b0;
      res_sum      <= '0;
      res_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_id     <= pick_id;
            eng_cypher   <= req_cypher[int'(pick_id)*16 +: 16];
            eng_compared <= req_compared[int'(pick_id)*4 +: 4];
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + 1'b1;
          if (eng_done) begin
            res_match   <= eng_match;
            res_sum     <= eng_sum;
            res_timeout <= 1'b0;
          end else if (wait_expired) begin
            res_match   <= 1'b0;
            res_sum     <= '0;
            res_timeout <= 1'b1;
          end
        end
        RESP: last_grant <= grant_id;
        default: ;
      endcase
    end
  end

  // Strobes decoded from state so each lasts exactly one cycle.
  always_comb begin
    eng_read = (state == ISSUE);
    busy     = (state != IDLE);
    ack      = (state == RESP) ? (NREQ'(1) << grant_id) : '0;
  end

endmodule
